// File: rtl/airlock_pkg.sv
// -----------------------------------------------------------------------------
// airlock_pkg
// Shared definitions for the lock-chamber interlock controller: state width,
// state encodings, error codes and small state-classification helpers used by
// the FSM and the watchdog.
// -----------------------------------------------------------------------------
package airlock_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE             = 4'h0,
    ST_PREP             = 4'h1,
    ST_WAIT_FILL        = 4'h2,
    ST_FILLING          = 4'h3,
    ST_WAIT_IPORT_OPEN  = 4'h4,
    ST_WAIT_OPORT_OPEN  = 4'h5,
    ST_WAIT_DRAIN       = 4'h6,
    ST_DRAINING         = 4'h7,
    ST_WAIT_IPORT_CLOSE = 4'h8,
    ST_WAIT_OPORT_CLOSE = 4'h9,
    ST_WAIT_USER        = 4'hA,
    ST_ERROR            = 4'hB
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_BOTH_OPEN = 2'd1,
    ERR_ILLEGAL   = 2'd2,
    ERR_TIMEOUT   = 2'd3
  } err_code_e;

  // States whose duration is set by the shared phase timer.
  function automatic logic is_timed(input state_e s);
    return (s == ST_PREP) || (s == ST_FILLING) || (s == ST_DRAINING);
  endfunction

  // States that wait on an operator command or a gate sensor.
  function automatic logic is_wait(input state_e s);
    return (s == ST_WAIT_FILL)        || (s == ST_WAIT_IPORT_OPEN)  ||
           (s == ST_WAIT_OPORT_OPEN)  || (s == ST_WAIT_DRAIN)       ||
           (s == ST_WAIT_IPORT_CLOSE) || (s == ST_WAIT_OPORT_CLOSE) ||
           (s == ST_WAIT_USER);
  endfunction

  // The outer gate may only be open while the controller is cycling it.
  function automatic logic oport_allowed(input state_e s);
    return (s == ST_WAIT_OPORT_OPEN) || (s == ST_WAIT_OPORT_CLOSE);
  endfunction

  // The inner gate may be open at rest or while the controller is cycling it.
  function automatic logic iport_allowed(input state_e s);
    return (s == ST_IDLE) || (s == ST_WAIT_USER) ||
           (s == ST_WAIT_IPORT_OPEN) || (s == ST_WAIT_IPORT_CLOSE);
  endfunction

endpackage

// File: rtl/airlock_ctrl_if.sv
// -----------------------------------------------------------------------------
// airlock_ctrl_if
// Bundles the controller's switch inputs and status outputs.
//   master : drives arrive/depart/fill/drain/iport/oport, observes status
//   slave  : the controller itself
// Signals: arrive (pulse), depart, fill, drain, iport, oport (levels);
//          state[3:0], busy, prep_led, fill_led, drain_led, pend[3:0],
//          err, err_code[1:0].
// -----------------------------------------------------------------------------
interface airlock_ctrl_if;
  import airlock_pkg::*;

  logic               arrive;
  logic               depart;
  logic               fill;
  logic               drain;
  logic               iport;
  logic               oport;
  logic [STATE_W-1:0] state;
  logic               busy;
  logic               prep_led;
  logic               fill_led;
  logic               drain_led;
  logic [3:0]         pend;
  logic               err;
  logic [1:0]         err_code;

  modport master (
    output arrive, depart, fill, drain, iport, oport,
    input  state, busy, prep_led, fill_led, drain_led, pend, err, err_code
  );

  modport slave (
    input  arrive, depart, fill, drain, iport, oport,
    output state, busy, prep_led, fill_led, drain_led, pend, err, err_code
  );

endinterface

// File: rtl/airlock_phase_timer.sv
// -----------------------------------------------------------------------------
// airlock_phase_timer
// Phase timer shared by the PREP, FILLING and DRAINING states.
//   clk, rst_n    : clock, asynchronous active-low reset
//   clr_i         : force the count to zero on the next edge (wins over en_i)
//   en_i          : advance the count
//   last_i        : terminal value for the current phase (N-1)
//   tc_o          : count currently equals last_i
//   blink_next_o  : BLINK_BIT of the value the count takes on the next edge,
//                   so a registered LED downstream lines up with the count
// -----------------------------------------------------------------------------
module airlock_phase_timer #(
  parameter int CNT_W     = 27,
  parameter int BLINK_BIT = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] last_i,
  output logic             tc_o,
  output logic             blink_next_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear, advance or hold.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = {CNT_W{1'b0}};
    end else if (en_i) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o         = (count_q == last_i);
  assign blink_next_o = count_d[BLINK_BIT];

endmodule

// File: rtl/airlock_ctrl.sv
// -----------------------------------------------------------------------------
// airlock_ctrl
// Lock-chamber interlock controller. Sequences prep, fill, outer gate, drain
// and inner gate for each boat, queues arrivals that come in while busy, and
// latches a sticky coded error on any illegal gate condition.
//   clock : system clock (rising edge)
//   reset : asynchronous active-low reset
//   bus   : airlock_ctrl_if.slave (switch inputs in, status outputs out)
// Optional feature: define AIRLOCK_TIMEOUT_EN to add a wait-state watchdog
// that raises error code 3 after TIMEOUT_CYCLES cycles in any WAIT_* state.
// -----------------------------------------------------------------------------
module airlock_ctrl
  import airlock_pkg::*;
#(
  parameter int PREP_CYCLES    = 33554432,
  parameter int FILL_CYCLES    = 33554432,
  parameter int DRAIN_CYCLES   = 33554432,
  parameter int CNT_W          = 27,
  parameter int BLINK_BIT      = 22,
  parameter int PEND_MAX       = 3,
  parameter int TIMEOUT_CYCLES = 1073741823
) (
  input  logic          clock,
  input  logic          reset,
  airlock_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] PREP_LAST  = CNT_W'(PREP_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [3:0]       PEND_SAT   = 4'(PEND_MAX);

  state_e           state_q, state_d;
  err_code_e        err_code_q, err_code_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic [3:0]       pend_q, pend_d;
  logic             prep_led_q, prep_led_d;
  logic             fill_led_q, fill_led_d;
  logic             drain_led_q, drain_led_d;

  logic [CNT_W-1:0] timer_last_s;
  logic             timer_clr_s;
  logic             timer_tc_s;
  logic             timer_blink_s;
  logic             timeout_hit_s;

  // Terminal value for whichever timed phase is active.
  always_comb begin
    timer_last_s = {CNT_W{1'b0}};
    case (state_q)
      ST_PREP:     timer_last_s = PREP_LAST;
      ST_FILLING:  timer_last_s = FILL_LAST;
      ST_DRAINING: timer_last_s = DRAIN_LAST;
      default:     timer_last_s = {CNT_W{1'b0}};
    endcase
  end

  // Timer runs only while staying in the same timed state, so it reads 0 on
  // entry to each timed phase and stays 0 everywhere else.
  assign timer_clr_s = !(is_timed(state_q) && (state_d == state_q));

  airlock_phase_timer #(
    .CNT_W     (CNT_W),
    .BLINK_BIT (BLINK_BIT)
  ) u_phase_timer (
    .clk          (clock),
    .rst_n        (reset),
    .clr_i        (timer_clr_s),
    .en_i         (1'b1),
    .last_i       (timer_last_s),
    .tc_o         (timer_tc_s),
    .blink_next_o (timer_blink_s)
  );

`ifdef AIRLOCK_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;

  // Watchdog counts cycles spent in the current wait state.
  always_comb begin
    wd_d = {WD_W{1'b0}};
    if ((state_d == state_q) && is_wait(state_q)) begin
      wd_d = wd_q + {{(WD_W-1){1'b0}}, 1'b1};
    end else begin
      wd_d = {WD_W{1'b0}};
    end
  end

  // Watchdog register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_q <= {WD_W{1'b0}};
    end else begin
      wd_q <= wd_d;
    end
  end

  // Firing on the last counted cycle makes the stay exactly TIMEOUT_CYCLES.
  assign timeout_hit_s = is_wait(state_q) && (wd_q == WD_LAST);
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Next state and error code; gate checks pre-empt the normal sequence.
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    if (state_q == ST_ERROR) begin
      state_d    = ST_ERROR;
      err_code_d = err_code_q;
    end else if (bus.iport && bus.oport) begin
      state_d    = ST_ERROR;
      err_code_d = ERR_BOTH_OPEN;
    end else if ((bus.oport && !oport_allowed(state_q)) ||
                 (bus.iport && !iport_allowed(state_q))) begin
      state_d    = ST_ERROR;
      err_code_d = ERR_ILLEGAL;
    end else if (timeout_hit_s) begin
      state_d    = ST_ERROR;
      err_code_d = ERR_TIMEOUT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.arrive || (pend_q != 4'd0)) begin
            state_d = ST_PREP;
          end else if (bus.iport) begin
            state_d = ST_WAIT_USER;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT_USER:        state_d = (!bus.iport && bus.depart) ? ST_PREP : ST_WAIT_USER;
        ST_PREP:             state_d = timer_tc_s ? ST_WAIT_FILL : ST_PREP;
        ST_WAIT_FILL:        state_d = bus.fill ? ST_FILLING : ST_WAIT_FILL;
        ST_FILLING:          state_d = timer_tc_s ? ST_WAIT_OPORT_OPEN : ST_FILLING;
        ST_WAIT_OPORT_OPEN:  state_d = bus.oport ? ST_WAIT_OPORT_CLOSE : ST_WAIT_OPORT_OPEN;
        ST_WAIT_OPORT_CLOSE: state_d = !bus.oport ? ST_WAIT_DRAIN : ST_WAIT_OPORT_CLOSE;
        ST_WAIT_DRAIN:       state_d = bus.drain ? ST_DRAINING : ST_WAIT_DRAIN;
        ST_DRAINING:         state_d = timer_tc_s ? ST_WAIT_IPORT_OPEN : ST_DRAINING;
        ST_WAIT_IPORT_OPEN:  state_d = bus.iport ? ST_WAIT_IPORT_CLOSE : ST_WAIT_IPORT_OPEN;
        ST_WAIT_IPORT_CLOSE: state_d = !bus.iport ? ST_IDLE : ST_WAIT_IPORT_CLOSE;
        default: begin
          // Unused encodings are treated as a fault rather than silently recovered.
          state_d    = ST_ERROR;
          err_code_d = ERR_ILLEGAL;
        end
      endcase
    end
  end

  // Pending-arrival queue: count arrivals while busy, consume one per auto-start.
  always_comb begin
    pend_d = pend_q;
    if (state_q == ST_ERROR) begin
      pend_d = pend_q;
    end else if (state_q == ST_IDLE) begin
      // A same-cycle arrive is the boat being served, so the queue is untouched.
      if (!bus.arrive && (pend_q != 4'd0) && (state_d == ST_PREP)) begin
        pend_d = pend_q - 4'd1;
      end else begin
        pend_d = pend_q;
      end
    end else if (bus.arrive && (pend_q < PEND_SAT)) begin
      pend_d = pend_q + 4'd1;
    end else begin
      pend_d = pend_q;
    end
  end

  // Status outputs derived from the next state so the registers track state_q.
  always_comb begin
    err_d       = err_q | (state_d == ST_ERROR);
    busy_d      = (state_d != ST_IDLE) && (state_d != ST_ERROR);
    prep_led_d  = (state_d == ST_PREP)     && timer_blink_s;
    fill_led_d  = (state_d == ST_FILLING)  && timer_blink_s;
    drain_led_d = (state_d == ST_DRAINING) && timer_blink_s;
  end

  // Controller state and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      err_code_q  <= ERR_NONE;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      pend_q      <= 4'd0;
      prep_led_q  <= 1'b0;
      fill_led_q  <= 1'b0;
      drain_led_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_code_q  <= err_code_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      pend_q      <= pend_d;
      prep_led_q  <= prep_led_d;
      fill_led_q  <= fill_led_d;
      drain_led_q <= drain_led_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.busy      = busy_q;
  assign bus.prep_led  = prep_led_q;
  assign bus.fill_led  = fill_led_q;
  assign bus.drain_led = drain_led_q;
  assign bus.pend      = pend_q;
  assign bus.err       = err_q;
  assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_airlock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_airlock_ctrl
// Directed bench for airlock_ctrl with short phases (8 cycles), BLINK_BIT=1,
// PEND_MAX=3 and TIMEOUT_CYCLES=16. Inputs change 1 time unit after the rising
// edge; outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_airlock_ctrl;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_err;

  airlock_ctrl_if bus ();

  airlock_ctrl #(
    .PREP_CYCLES    (8),
    .FILL_CYCLES    (8),
    .DRAIN_CYCLES   (8),
    .CNT_W          (4),
    .BLINK_BIT      (1),
    .PEND_MAX       (3),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_state"}, 32'(bus.state), 32'h0);
    check_val({tag, "_busy"}, 32'(bus.busy), 32'h0);
    check_val({tag, "_pend"}, 32'(bus.pend), 32'h0);
    check_val({tag, "_err"}, 32'(bus.err), 32'h0);
    check_val({tag, "_code"}, 32'(bus.err_code), 32'h0);
    check_val({tag, "_leds"}, 32'({bus.prep_led, bus.fill_led, bus.drain_led}), 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.arrive = 1'b0; bus.depart = 1'b0; bus.fill = 1'b0;
    bus.drain  = 1'b0; bus.iport  = 1'b0; bus.oport = 1'b0;
    ticks(2);
    reset = 1'b1;
    tick();
  endtask

  // Arrive from IDLE, run PREP, land in WAIT_FILL.
  task automatic to_wait_fill();
    bus.arrive = 1'b1; tick(); bus.arrive = 1'b0;
    ticks(8);
  endtask

  // From WAIT_FILL through FILLING into WAIT_OPORT_OPEN.
  task automatic to_wait_oport_open();
    bus.fill = 1'b1; tick(); bus.fill = 1'b0;
    ticks(8);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // Reset state.
    do_reset();
    check_idle_outputs("reset");

    // PREP lasts exactly 8 cycles, LED blinks with timer bit 1.
    bus.arrive = 1'b1; tick(); bus.arrive = 1'b0;
    for (int j = 0; j < 8; j++) begin
      check_val("prep_state", 32'(bus.state), 32'h1);
      check_val("prep_led", 32'(bus.prep_led), 32'((j >> 1) & 1));
      tick();
    end
    check_val("wfill_state", 32'(bus.state), 32'h2);
    check_val("wfill_busy", 32'(bus.busy), 32'h1);
    check_val("wfill_led", 32'(bus.prep_led), 32'h0);

    // FILLING with four arrive pulses; pend saturates at 3.
    bus.fill = 1'b1; tick(); bus.fill = 1'b0;
    for (int j = 0; j < 8; j++) begin
      check_val("fill_state", 32'(bus.state), 32'h3);
      check_val("fill_led", 32'(bus.fill_led), 32'((j >> 1) & 1));
      bus.arrive = (j >= 1 && j <= 4);
      tick();
      bus.arrive = 1'b0;
    end
    check_val("woo_state", 32'(bus.state), 32'h5);
    check_val("pend_sat", 32'(bus.pend), 32'h3);

    // Outer gate cycle.
    bus.oport = 1'b1; tick();
    check_val("woc_state", 32'(bus.state), 32'h9);
    bus.oport = 1'b0; tick();
    check_val("wdrain_state", 32'(bus.state), 32'h6);

    // DRAINING.
    bus.drain = 1'b1; tick(); bus.drain = 1'b0;
    for (int j = 0; j < 8; j++) begin
      check_val("drain_state", 32'(bus.state), 32'h7);
      check_val("drain_led", 32'(bus.drain_led), 32'((j >> 1) & 1));
      tick();
    end
    check_val("wio_state", 32'(bus.state), 32'h4);

    // Inner gate cycle and return to IDLE, then auto-start from the queue.
    bus.iport = 1'b1; tick();
    check_val("wic_state", 32'(bus.state), 32'h8);
    bus.iport = 1'b0; tick();
    check_val("ret_state", 32'(bus.state), 32'h0);
    check_val("ret_busy", 32'(bus.busy), 32'h0);
    check_val("ret_pend", 32'(bus.pend), 32'h3);
    tick();
    check_val("auto_state", 32'(bus.state), 32'h1);
    check_val("auto_pend", 32'(bus.pend), 32'h2);
    check_val("auto_busy", 32'(bus.busy), 32'h1);

    // Outer gate in WAIT_FILL -> ERROR code 2, sticky against later faults.
    ticks(8);
    check_val("e2_pre", 32'(bus.state), 32'h2);
    bus.oport = 1'b1; tick();
    check_val("e2_state", 32'(bus.state), 32'hB);
    check_val("e2_err", 32'(bus.err), 32'h1);
    check_val("e2_code", 32'(bus.err_code), 32'h2);
    check_val("e2_busy", 32'(bus.busy), 32'h0);
    bus.iport = 1'b1;
    bus.arrive = 1'b1; tick(); bus.arrive = 1'b0;
    check_val("e2_sticky", 32'(bus.err_code), 32'h2);
    check_val("e2_hold", 32'(bus.state), 32'hB);
    check_val("e2_pendfrz", 32'(bus.pend), 32'h2);
    do_reset();
    check_idle_outputs("rel");

    // Both gates open in WAIT_OPORT_OPEN -> code 1.
    to_wait_fill();
    to_wait_oport_open();
    check_val("e1_pre", 32'(bus.state), 32'h5);
    bus.iport = 1'b1; bus.oport = 1'b1; tick();
    check_val("e1_state", 32'(bus.state), 32'hB);
    check_val("e1_code", 32'(bus.err_code), 32'h1);
    do_reset();

    // Asynchronous reset mid-FILLING.
    to_wait_fill();
    bus.fill = 1'b1; tick(); bus.fill = 1'b0;
    ticks(2);
    check_val("ar_pre", 32'(bus.state), 32'h3);
    #2;
    reset = 1'b0;
    #1;
    check_val("ar_state", 32'(bus.state), 32'h0);
    check_val("ar_busy", 32'(bus.busy), 32'h0);
    check_val("ar_led", 32'(bus.fill_led), 32'h0);
    #10;
    reset = 1'b1;
    tick();

    // Holding WAIT_DRAIN: watchdog fires after 16 cycles only when enabled.
    to_wait_fill();
    to_wait_oport_open();
    bus.oport = 1'b1; tick();
    bus.oport = 1'b0; tick();
    check_val("to_entry", 32'(bus.state), 32'h6);
    ticks(15);
    check_val("to_15", 32'(bus.state), 32'h6);
    tick();
`ifdef AIRLOCK_TIMEOUT_EN
    check_val("to_state", 32'(bus.state), 32'hB);
    check_val("to_code", 32'(bus.err_code), 32'h3);
`else
    check_val("to_state", 32'(bus.state), 32'h6);
    check_val("to_code", 32'(bus.err_code), 32'h0);
`endif
    ticks(4);
`ifdef AIRLOCK_TIMEOUT_EN
    check_val("to_hold", 32'(bus.state), 32'hB);
`else
    check_val("to_hold", 32'(bus.state), 32'h6);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
